am4_mcseq: RTL and testbench

Microprogram sequencer that generates the 10-bit microinstruction address driving the microcode ROM address input. The ROM registers its address on the rising clock edge. The block sits directly upstream of the ROM. It holds the micro-program counter (uPC), a return-address stack and a loop counter, and selects the next address from uPC, stack top or the direct field. It is a reduced Am2910-style sequencer for the M4 datapath.

---
 rtl/am4_mcseq.sv | 150 +++++++++++++++
 tb/tb_am4_mcseq.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/am4_mcseq.sv
// Reduced Am2910-style microprogram sequencer: uPC, return stack, optional loop counter.
// Optional loop counter is built only when AM4_MCSEQ_CNT_EN is defined.
module am4_mcseq #(
  parameter int AW = 10,
  parameter int SD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic [2:0]    op,
  input  logic          cc,
  input  logic          cin,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] y,
  output logic          full,
  output logic          empty,
  output logic          cnt_z
);

  localparam int SPW = $clog2(SD + 1);

  typedef enum logic [2:0] {
    OP_JZ   = 3'd0,
    OP_CJS  = 3'd1,
    OP_JMAP = 3'd2,
    OP_CJP  = 3'd3,
    OP_PUSH = 3'd4,
    OP_CRTN = 3'd5,
    OP_LDCT = 3'd6,
    OP_RPCT = 3'd7
  } op_e;

  logic [AW-1:0]  upc_q, upc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [AW-1:0]  stk_q [SD];
  logic [AW-1:0]  tos;
  logic [AW-1:0]  y_sel;
  logic [SD-1:0]  wr_sel;
  logic           push, pop, clr;
  logic           full_w, empty_w;

`ifdef AM4_MCSEQ_CNT_EN
  logic [AW-1:0]  cnt_q, cnt_d;
  logic           cnt_nz;

  assign cnt_nz = |cnt_q;
  assign cnt_z  = ~cnt_nz;
`else
  assign cnt_z  = 1'b1;
`endif

  assign full_w  = (sp_q == SPW'(SD));
  assign empty_w = (sp_q == '0);
  assign full    = full_w;
  assign empty   = empty_w;

  // Empty stack reads as zero because no entry matches sp-1.
  always_comb begin
    tos = '0;
    for (int i = 0; i < SD; i++) begin
      if (sp_q == SPW'(i + 1)) tos = stk_q[i];
    end
  end

  // A push into a full stack lands on the top slot instead of growing.
  always_comb begin
    for (int i = 0; i < SD; i++) begin
      wr_sel[i] = (sp_q == SPW'(i)) || (full_w && (i == SD - 1));
    end
  end

  always_comb begin
    y_sel = upc_q;
    push  = 1'b0;
    pop   = 1'b0;
    clr   = 1'b0;
`ifdef AM4_MCSEQ_CNT_EN
    cnt_d = cnt_q;
`endif
    case (op_e'(op))
      OP_JZ: begin
        y_sel = '0;
        clr   = 1'b1;
      end
      OP_CJS: begin
        if (cc) begin
          y_sel = d;
          push  = 1'b1;
        end
      end
      OP_JMAP: y_sel = d;
      OP_CJP: begin
        if (cc) y_sel = d;
      end
      OP_PUSH: begin
        push = 1'b1;
`ifdef AM4_MCSEQ_CNT_EN
        if (cc) cnt_d = d;
`endif
      end
      OP_CRTN: begin
        if (cc) begin
          y_sel = tos;
          pop   = 1'b1;
        end
      end
`ifdef AM4_MCSEQ_CNT_EN
      OP_LDCT: cnt_d = d;
      OP_RPCT: begin
        if (cnt_nz) begin
          y_sel = d;
          cnt_d = cnt_q - 1'b1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    sp_d = sp_q;
    if (clr)                 sp_d = '0;
    else if (push && !full_w) sp_d = sp_q + 1'b1;
    else if (pop && !empty_w) sp_d = sp_q - 1'b1;
  end

  assign upc_d = y_sel + AW'(cin);
  assign y     = rst_n ? y_sel : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc_q <= '0;
      sp_q  <= '0;
      for (int i = 0; i < SD; i++) stk_q[i] <= '0;
`ifdef AM4_MCSEQ_CNT_EN
      cnt_q <= '0;
`endif
    end else if (ce) begin
      upc_q <= upc_d;
      sp_q  <= sp_d;
      for (int i = 0; i < SD; i++) begin
        if (push && wr_sel[i]) stk_q[i] <= upc_q;
      end
`ifdef AM4_MCSEQ_CNT_EN
      cnt_q <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_am4_mcseq.sv
// Self-checking bench for am4_mcseq with a queue-based reference model.
// Follows AM4_MCSEQ_CNT_EN to select the counter-present or counter-absent model.
module tb_am4_mcseq;
  localparam int AW = 10;
  localparam int SD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic [2:0]    op = 3'd0;
  logic          cc = 1'b0;
  logic          cin = 1'b0;
  logic [AW-1:0] d = '0;
  logic [AW-1:0] y;
  logic          full, empty, cnt_z;

  int total = 0;
  int bad   = 0;

  int m_upc;
  int m_cnt;
  int m_stk[$];

  always #5 clk = ~clk;

  am4_mcseq #(.AW(AW), .SD(SD)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .op(op), .cc(cc), .cin(cin), .d(d),
    .y(y), .full(full), .empty(empty), .cnt_z(cnt_z)
  );

  function automatic bit cnt_en();
`ifdef AM4_MCSEQ_CNT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int m_tos();
    return (m_stk.size() > 0) ? m_stk[m_stk.size()-1] : 0;
  endfunction

  function automatic logic [AW-1:0] m_y();
    int r;
    case (op)
      3'd0: r = 0;
      3'd1: r = cc ? int'(d) : m_upc;
      3'd2: r = int'(d);
      3'd3: r = cc ? int'(d) : m_upc;
      3'd5: r = cc ? m_tos() : m_upc;
      3'd7: r = (cnt_en() && m_cnt != 0) ? int'(d) : m_upc;
      default: r = m_upc;
    endcase
    return AW'(r);
  endfunction

  function automatic logic m_full();
    return m_stk.size() == SD;
  endfunction

  function automatic logic m_empty();
    return m_stk.size() == 0;
  endfunction

  function automatic logic m_cntz();
    return cnt_en() ? (m_cnt == 0) : 1'b1;
  endfunction

  task automatic m_reset();
    m_upc = 0;
    m_cnt = 0;
    m_stk.delete();
  endtask

  task automatic m_push();
    if (m_stk.size() < SD) m_stk.push_back(m_upc);
    else m_stk[SD-1] = m_upc;
  endtask

  task automatic m_step();
    int ny;
    if (!ce) return;
    ny = int'(m_y());
    case (op)
      3'd0: m_stk.delete();
      3'd1: if (cc) m_push();
      3'd4: begin
        m_push();
        if (cc && cnt_en()) m_cnt = int'(d);
      end
      3'd5: if (cc && m_stk.size() > 0) void'(m_stk.pop_back());
      3'd6: if (cnt_en()) m_cnt = int'(d);
      3'd7: if (cnt_en() && m_cnt != 0) m_cnt = m_cnt - 1;
      default: ;
    endcase
    m_upc = (ny + int'(cin)) % (1 << AW);
  endtask

  // Called at edge+1; leaves inputs settled at edge+4 for checking.
  task automatic drv(input logic [2:0] o, input logic c, input logic ci,
                     input logic [AW-1:0] dd, input logic e);
    op = o; cc = c; cin = ci; d = dd; ce = e;
    #3;
  endtask

  task automatic adv();
    if (rst_n) m_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    op = 3'd3; cc = 1'b1; d = 10'h155; ce = 1'b0; cin = 1'b1;
    #2;
    total++; if (y !== '0) begin bad++; $display("FAIL reset y: got %h want 000", y); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset empty: got %b want 1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset full: got %b want 0", full); end
    total++; if (cnt_z !== 1'b1) begin bad++; $display("FAIL reset cnt_z: got %b want 1", cnt_z); end
    @(negedge clk);
    rst_n = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_seq();
    for (int i = 0; i < 4; i++) begin
      drv(3'd3, 1'b0, 1'b1, 10'h2C3, 1'b1);
      total++; if (y !== AW'(i)) begin bad++; $display("FAIL seq y[%0d]: got %h want %h", i, y, i); end
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL seq empty[%0d]: got %b want 1", i, empty); end
      adv();
    end
  endtask

  task automatic test_wrap();
    drv(3'd3, 1'b1, 1'b1, 10'h3FE, 1'b1); adv();
    drv(3'd3, 1'b0, 1'b1, 10'h000, 1'b1);
    total++; if (y !== 10'h3FF) begin bad++; $display("FAIL wrap top: got %h want 3ff", y); end
    adv();
    drv(3'd3, 1'b0, 1'b1, 10'h000, 1'b1);
    total++; if (y !== 10'h000) begin bad++; $display("FAIL wrap zero: got %h want 000", y); end
    adv();
  endtask

  task automatic test_call();
    drv(3'd0, 1'b0, 1'b1, 10'h000, 1'b1); adv();
    drv(3'd3, 1'b1, 1'b1, 10'h010, 1'b1); adv();
    drv(3'd1, 1'b1, 1'b1, 10'h120, 1'b1);
    total++; if (y !== 10'h120) begin bad++; $display("FAIL call y: got %h want 120", y); end
    adv();
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL call depth: empty=%b want 0", empty); end
    drv(3'd3, 1'b0, 1'b1, 10'h000, 1'b1); adv();
    drv(3'd5, 1'b1, 1'b1, 10'h0F0, 1'b1);
    total++; if (y !== 10'h011) begin bad++; $display("FAIL return y: got %h want 011", y); end
    adv();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL return empty: got %b want 1", empty); end
  endtask

  task automatic test_overflow();
    logic [AW-1:0] pops [5];
    pops[0] = 10'h005; pops[1] = 10'h003; pops[2] = 10'h002;
    pops[3] = 10'h001; pops[4] = 10'h000;
    drv(3'd0, 1'b0, 1'b1, 10'h000, 1'b1); adv();
    for (int k = 1; k <= 5; k++) begin
      drv(3'd4, 1'b0, 1'b1, 10'h000, 1'b1);
      total++; if (y !== AW'(k)) begin bad++; $display("FAIL push y[%0d]: got %h want %h", k, y, k); end
      adv();
      total++;
      if (full !== (k >= 4)) begin bad++; $display("FAIL push full[%0d]: got %b want %b", k, full, k >= 4); end
    end
    for (int k = 0; k < 5; k++) begin
      drv(3'd5, 1'b1, 1'b1, 10'h000, 1'b1);
      total++; if (y !== pops[k]) begin bad++; $display("FAIL pop y[%0d]: got %h want %h", k, y, pops[k]); end
      adv();
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL pop empty: got %b want 1", empty); end
  endtask

  task automatic test_counter();
    logic [AW-1:0] ey;
    drv(3'd6, 1'b0, 1'b1, 10'h003, 1'b1); adv();
    total++;
    if (cnt_z !== !cnt_en()) begin bad++; $display("FAIL ldct cnt_z: got %b want %b", cnt_z, !cnt_en()); end
    for (int k = 0; k < 4; k++) begin
      drv(3'd7, 1'b0, 1'b1, 10'h050, 1'b1);
      ey = (cnt_en() && k < 3) ? 10'h050 : AW'(m_upc);
      total++; if (y !== ey) begin bad++; $display("FAIL rpct y[%0d]: got %h want %h", k, y, ey); end
      adv();
    end
    total++; if (cnt_z !== 1'b1) begin bad++; $display("FAIL rpct cnt_z: got %b want 1", cnt_z); end
  endtask

  task automatic test_ce_hold();
    int saved;
    drv(3'd0, 1'b0, 1'b1, 10'h000, 1'b1); adv();
    saved = m_upc;
    for (int k = 0; k < 3; k++) begin
      drv(3'd1, 1'b1, 1'b1, 10'h2A5, 1'b0);
      total++; if (y !== 10'h2A5) begin bad++; $display("FAIL hold y[%0d]: got %h want 2a5", k, y); end
      adv();
      total++; if (empty !== 1'b1) begin bad++; $display("FAIL hold sp[%0d]: empty=%b want 1", k, empty); end
    end
    drv(3'd3, 1'b0, 1'b1, 10'h000, 1'b1);
    total++; if (y !== AW'(saved)) begin bad++; $display("FAIL hold upc: got %h want %h", y, saved); end
    adv();
  endtask

  task automatic test_reset_mid();
    drv(3'd1, 1'b1, 1'b1, 10'h0AA, 1'b1); adv();
    drv(3'd3, 1'b0, 1'b1, 10'h000, 1'b1);
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL pre-rst empty: got %b want 0", empty); end
    rst_n = 1'b0;
    #1;
    total++; if (y !== '0) begin bad++; $display("FAIL mid-rst y: got %h want 000", y); end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid-rst empty: got %b want 1", empty); end
    m_reset();
    #2;
    rst_n = 1'b1;
    #1;
    total++; if (y !== '0) begin bad++; $display("FAIL post-rst y: got %h want 000", y); end
    adv();
    drv(3'd3, 1'b0, 1'b1, 10'h000, 1'b1);
    total++; if (y !== 10'h001) begin bad++; $display("FAIL post-rst next: got %h want 001", y); end
    adv();
  endtask

  task automatic test_random();
    logic [2:0] o;
    logic [AW-1:0] ey;
    for (int n = 0; n < 400; n++) begin
      o = 3'($urandom_range(0, 7));
      if (o == 3'd0 && ($urandom % 4) != 0) o = 3'd4;
      drv(o, 1'($urandom), 1'(($urandom % 8) != 0), AW'($urandom), 1'(($urandom % 5) != 0));
      ey = m_y();
      total++; if (y !== ey) begin bad++; $display("FAIL rnd y[%0d] op=%0d: got %h want %h", n, o, y, ey); end
      total++; if (full !== m_full()) begin bad++; $display("FAIL rnd full[%0d]: got %b want %b", n, full, m_full()); end
      total++; if (empty !== m_empty()) begin bad++; $display("FAIL rnd empty[%0d]: got %b want %b", n, empty, m_empty()); end
      total++; if (cnt_z !== m_cntz()) begin bad++; $display("FAIL rnd cnt_z[%0d]: got %b want %b", n, cnt_z, m_cntz()); end
      adv();
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_seq();
    test_wrap();
    test_call();
    test_overflow();
    test_counter();
    test_ce_hold();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
